y_packer: RTL and testbench

Stream-to-SRAM packer that builds the packed 256-bit sparse-matrix words consumed by the decoder. It accepts one matrix element per cycle (48-bit value, 11-bit column, new-row flag) and groups four elements per word. Completed words are written sequentially into y_sram's write port. It is the writer at the front of the SpMV pipeline; `y_arbiter`/`decoder` are the readers.

---
 rtl/y_packer.sv | 139 +++++++++++++
 tb/tb_y_packer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_packer.sv
// Stream-to-SRAM packer: groups four 64-bit element slots into 256-bit y_sram words.
// Optional macro Y_PACKER_PARITY_EN puts even parity over {col, value} in slot bit 61.
module y_packer #(
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [47:0]  in_value,
  input  logic [10:0]  in_col,
  input  logic         in_newrow,
  input  logic         in_last,
  output logic [10:0]  WriteAddress,
  output logic [255:0] WriteBus,
  output logic         WriteEnable,
  output logic [11:0]  word_count,
  output logic         done,
  output logic         overflow
);

  typedef enum logic [1:0] {StIdle, StFill, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0][63:0]   slots_q, slots_d;
  logic [1:0]         slot_idx_q, slot_idx_d;
  logic               full_q, full_d;
  logic               in_ready_q, in_ready_d;
  logic               we_q, we_d;
  logic [10:0]        waddr_q, waddr_d;
  logic [255:0]       wbus_q, wbus_d;
  logic [11:0]        wcount_q, wcount_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic [63:0]        slot_new;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    slot_new = {1'b1, in_newrow, 1'b0, 2'b00, in_col, in_value};
`ifdef Y_PACKER_PARITY_EN
    slot_new[61] = ^{in_col, in_value};
`endif
  end

  always_comb begin
    state_d    = state_q;
    slots_d    = slots_q;
    slot_idx_d = slot_idx_q;
    full_d     = full_q;
    in_ready_d = in_ready_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wbus_d     = wbus_q;
    wcount_d   = wcount_q;
    overflow_d = overflow_q;

    if (start) begin
      // start beats any element offered in the same cycle; buffered data is dropped
      state_d    = StFill;
      slots_d    = '0;
      slot_idx_d = 2'd0;
      full_d     = 1'b0;
      wcount_d   = 12'd0;
      overflow_d = 1'b0;
      in_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StFill: begin
          if (in_valid && full_q) begin
            overflow_d = 1'b1;
          end
          if (accept) begin
            slots_d[slot_idx_q] = slot_new;
            if (slot_idx_q == 2'd3 || in_last) begin
              // output register is the second bank, so the buffer frees up at once
              we_d       = 1'b1;
              wbus_d     = slots_d;
              waddr_d    = wcount_q[10:0];
              wcount_d   = wcount_q + 12'd1;
              slots_d    = '0;
              slot_idx_d = 2'd0;
              if (wcount_q == 12'(MAX_WORDS - 1)) begin
                full_d = 1'b1;
              end
              if (in_last) begin
                state_d = StFlush;
              end
            end else begin
              slot_idx_d = slot_idx_q + 2'd1;
            end
          end
          in_ready_d = (state_d == StFill) && !full_d;
        end
        StFlush: state_d = StDone;
        StDone:  ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      slots_q    <= '0;
      slot_idx_q <= 2'd0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 11'd0;
      wbus_q     <= '0;
      wcount_q   <= 12'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slots_q    <= slots_d;
      slot_idx_q <= slot_idx_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wbus_q     <= wbus_d;
      wcount_q   <= wcount_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign WriteEnable  = we_q;
  assign WriteAddress = waddr_q;
  assign WriteBus     = wbus_q;
  assign word_count   = wcount_q;
  assign done         = (state_q == StDone);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_y_packer.sv
// Scoreboard bench for y_packer: stimulus pushes expected writes, a monitor pops on WriteEnable.
// A second instance with MAX_WORDS=2 shares the inputs to exercise the full/overflow path.
module tb_y_packer;

  logic         clock = 1'b0;
  logic         reset, start, in_valid, in_newrow, in_last;
  logic [47:0]  in_value;
  logic [10:0]  in_col;

  logic         in_ready, we, done, overflow;
  logic [10:0]  waddr;
  logic [255:0] wbus;
  logic [11:0]  wcount;

  logic         in_ready_s, we_s, done_s, overflow_s;
  logic [10:0]  waddr_s;
  logic [255:0] wbus_s;
  logic [11:0]  wcount_s;

  int checks = 0;
  int failures = 0;
  int small_writes = 0;

  typedef struct packed {
    logic [10:0]  addr;
    logic [255:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  y_packer #(.MAX_WORDS(2048)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_col(in_col), .in_newrow(in_newrow), .in_last(in_last),
    .WriteAddress(waddr), .WriteBus(wbus), .WriteEnable(we), .word_count(wcount),
    .done(done), .overflow(overflow)
  );

  y_packer #(.MAX_WORDS(2)) dut_s (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_value(in_value), .in_col(in_col), .in_newrow(in_newrow), .in_last(in_last),
    .WriteAddress(waddr_s), .WriteBus(wbus_s), .WriteEnable(we_s), .word_count(wcount_s),
    .done(done_s), .overflow(overflow_s)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_slot(input logic nr, input logic [10:0] col,
                                          input logic [47:0] val);
    logic [63:0] s;
    s = {1'b1, nr, 1'b0, 2'b00, col, val};
`ifdef Y_PACKER_PARITY_EN
    s[61] = ^{col, val};
`endif
    return s;
  endfunction

  task automatic push(input logic [10:0] addr, input logic [255:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic [47:0] v, input logic [10:0] c, input logic nr,
                      input logic last);
    in_value  = v;
    in_col    = c;
    in_newrow = nr;
    in_last   = last;
    in_valid  = 1'b1;
    chk("in_ready_on_send", {255'd0, in_ready}, 256'd1);
    cycle();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_newrow = 1'b0;
  endtask

  // Monitor: every strobe of the main DUT must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", waddr);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {245'd0, waddr}, {245'd0, e.addr});
          chk("write_bus", wbus, e.data);
          chk("word_count_at_write", {244'd0, wcount}, {244'd0, 12'({1'b0, e.addr} + 12'd1)});
        end
      end
    end
  end

  always @(negedge clock) if (we_s) small_writes++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] s0, s1, s2, s3;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_newrow = 1'b0; in_last = 1'b0;
    in_value = '0; in_col = '0;
    repeat (3) cycle();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_we", {255'd0, we}, 256'd0);
    chk("rst_addr", {245'd0, waddr}, 256'd0);
    chk("rst_bus", wbus, 256'd0);
    chk("rst_word_count", {244'd0, wcount}, 256'd0);
    chk("rst_done", {255'd0, done}, 256'd0);
    chk("rst_overflow", {255'd0, overflow}, 256'd0);
    cycle();

    // Four back-to-back elements make one full word at address 0.
    pulse_start();
    for (int i = 0; i < 4; i++) send(48'h10 + 48'(i), 11'(1 + i), i == 0, 1'b0);
    push(11'd0, {mk_slot(0, 11'd4, 48'h13), mk_slot(0, 11'd3, 48'h12),
                 mk_slot(0, 11'd2, 48'h11), mk_slot(1, 11'd1, 48'h10)});
    cycle();
    chk("t1_word_count", {244'd0, wcount}, 256'd1);

    // Six elements ending with in_last: a full word then a half word, then done.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(48'h20 + 48'(i), 11'(10 + i), (i == 0) || (i == 4), i == 5);
      if (i == 3)
        push(11'd0, {mk_slot(0, 11'd13, 48'h23), mk_slot(0, 11'd12, 48'h22),
                     mk_slot(0, 11'd11, 48'h21), mk_slot(1, 11'd10, 48'h20)});
    end
    push(11'd1, {64'd0, 64'd0, mk_slot(0, 11'd15, 48'h25), mk_slot(1, 11'd14, 48'h24)});
    chk("t2_done_during_write", {255'd0, done}, 256'd0);
    cycle();
    chk("t2_done", {255'd0, done}, 256'd1);
    chk("t2_ready_in_done", {255'd0, in_ready}, 256'd0);

    // in_valid on alternate cycles; in_ready must hold through the gaps.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(48'h30 + 48'(i), 11'(20 + i), i == 0, 1'b0);
      if (i == 3)
        push(11'd0, {mk_slot(0, 11'd23, 48'h33), mk_slot(0, 11'd22, 48'h32),
                     mk_slot(0, 11'd21, 48'h31), mk_slot(1, 11'd20, 48'h30)});
      if (i == 7)
        push(11'd1, {mk_slot(0, 11'd27, 48'h37), mk_slot(0, 11'd26, 48'h36),
                     mk_slot(0, 11'd25, 48'h35), mk_slot(0, 11'd24, 48'h34)});
      chk("t3_ready_gap", {255'd0, in_ready}, 256'd1);
      cycle();
    end

    // start after 3 buffered elements, with a colliding element that must be dropped.
    pulse_start();
    for (int i = 0; i < 3; i++) send(48'h40 + 48'(i), 11'(i), i == 0, 1'b0);
    start = 1'b1; in_valid = 1'b1; in_value = 48'hdead; in_col = 11'd99;
    cycle();
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(48'h50 + 48'(i), 11'(i), i == 0, 1'b0);
    push(11'd0, {mk_slot(0, 11'd3, 48'h53), mk_slot(0, 11'd2, 48'h52),
                 mk_slot(0, 11'd1, 48'h51), mk_slot(1, 11'd0, 48'h50)});
    cycle();

    // 12 elements: main instance writes 3 words, the 2-word instance fills and overflows.
    pulse_start();
    small_writes = 0;
    for (int i = 0; i < 12; i++) begin
      send(48'h60 + 48'(i), 11'(i), (i % 4) == 0, 1'b0);
      if ((i % 4) == 3) begin
        s0 = mk_slot(1, 11'(i - 3), 48'h60 + 48'(i - 3));
        s1 = mk_slot(0, 11'(i - 2), 48'h60 + 48'(i - 2));
        s2 = mk_slot(0, 11'(i - 1), 48'h60 + 48'(i - 1));
        s3 = mk_slot(0, 11'(i), 48'h60 + 48'(i));
        push(11'(i / 4), {s3, s2, s1, s0});
      end
    end
    cycle();
    cycle();
    chk("t5_small_writes", 256'(small_writes), 256'd2);
    chk("t5_small_ready", {255'd0, in_ready_s}, 256'd0);
    chk("t5_small_overflow", {255'd0, overflow_s}, 256'd1);
    chk("t5_small_count", {244'd0, wcount_s}, 256'd2);
    chk("t5_main_overflow", {255'd0, overflow}, 256'd0);

    // reset sampled with the slot-completing element suppresses the strobe.
    pulse_start();
    for (int i = 0; i < 3; i++) send(48'h70 + 48'(i), 11'(i), i == 0, 1'b0);
    in_valid = 1'b1; in_value = 48'h73; in_col = 11'd3; reset = 1'b1;
    cycle();
    in_valid = 1'b0; reset = 1'b0;
    chk("t6_no_strobe", {255'd0, we}, 256'd0);
    chk("t6_ready", {255'd0, in_ready}, 256'd0);
    chk("t6_count", {244'd0, wcount}, 256'd0);
    cycle();

    // Parity bit: value 1 col 0 has odd weight, value 3 col 0 has even weight.
    pulse_start();
    send(48'h1, 11'd0, 1'b1, 1'b0);
    send(48'h3, 11'd0, 1'b0, 1'b1);
`ifdef Y_PACKER_PARITY_EN
    push(11'd0, {64'd0, 64'd0, 64'h8000_0000_0000_0003, 64'hE000_0000_0000_0001});
`else
    push(11'd0, {64'd0, 64'd0, 64'h8000_0000_0000_0003, 64'hC000_0000_0000_0001});
`endif
    cycle();
    chk("t7_done", {255'd0, done}, 256'd1);

    cycle();
    cycle();
    chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
